// File: rtl/pkt_defs.sv
// Shared framing definitions for the packet builder and the receive-side parser/checker.
// Frame layout: SOF, LEN (payload byte count), payload bytes MSB-first, CSUM.
package pkt_defs;

  localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hA5;

  // SOF + LEN + CSUM bytes wrapped around the payload.
  localparam int unsigned FRAME_OVERHEAD   = 3;

  // Checksum rule: CSUM = LEN ^ (XOR of every payload byte). SOF is not covered.
  // A receiver XOR-ing LEN, all payload bytes and CSUM therefore obtains zero.

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_SOF     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;

  typedef enum logic [2:0] {
    StCollect = ST_COLLECT,
    StSof     = ST_SOF,
    StLen     = ST_LEN,
    StDataHi  = ST_DATA_HI,
    StDataLo  = ST_DATA_LO,
    StCsum    = ST_CSUM
  } state_e;

  function automatic logic [7:0] word_xor(input logic [15:0] w);
    return w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/pkt_word_buffer.sv
// Single-packet word store: synchronous write from the collect side, asynchronous read
// addressed by the transmit pointer.
module pkt_word_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_builder.sv
// Collects one packet of 16-bit words, then serializes it as SOF, LEN, payload bytes
// MSB-first and an XOR checksum, with valid/ready handshaking on the byte side.
module packet_builder
  import pkt_defs::*;
#(
  parameter int unsigned MAX_WORDS = 16,
  parameter logic [7:0]  SOF_BYTE  = SOF_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  input  logic        word_last,
  output logic        word_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_first,
  output logic        byte_last,
  output logic        pkt_sent
);

  localparam int unsigned AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_e      state_q, state_d;
  logic [6:0]  wcount_q, wcount_d;
  logic [6:0]  rptr_q, rptr_d;
  logic [7:0]  csum_q, csum_d;
  logic        pkt_sent_q, pkt_sent_d;

  logic [15:0] rd_word;
  logic [7:0]  len_byte;
  logic        word_acc;
  logic        close_pkt;

  assign len_byte  = {wcount_q, 1'b0};
  assign word_acc  = (state_q == StCollect) && word_valid;
  // The word filling the last slot closes the packet regardless of word_last.
  assign close_pkt = word_last || (({1'b0, wcount_q} + 8'd1) == 8'(MAX_WORDS));

  pkt_word_buffer #(
    .DEPTH (MAX_WORDS),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (word_acc),
    .waddr (wcount_q[AW-1:0]),
    .wdata (word_in),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StCollect;
      wcount_q   <= '0;
      rptr_q     <= '0;
      csum_q     <= '0;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcount_q   <= wcount_d;
      rptr_q     <= rptr_d;
      csum_q     <= csum_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcount_d   = wcount_q;
    rptr_d     = rptr_q;
    csum_d     = csum_q;
    pkt_sent_d = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (word_valid) begin
          wcount_d = wcount_q + 7'd1;
          csum_d   = ((wcount_q == '0) ? 8'h00 : csum_q) ^ word_xor(word_in);
          if (close_pkt) begin
            state_d = StSof;
          end
        end
      end
      StSof: begin
        if (byte_ready) state_d = StLen;
      end
      StLen: begin
        if (byte_ready) state_d = StDataHi;
      end
      StDataHi: begin
        if (byte_ready) state_d = StDataLo;
      end
      StDataLo: begin
        if (byte_ready) begin
          rptr_d  = rptr_q + 7'd1;
          state_d = (rptr_q == wcount_q - 7'd1) ? StCsum : StDataHi;
        end
      end
      StCsum: begin
        if (byte_ready) begin
          state_d    = StCollect;
          wcount_d   = '0;
          rptr_d     = '0;
          csum_d     = '0;
          pkt_sent_d = 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Outputs decode from registered state only; byte_ready never reaches byte_out.
  always_comb begin
    byte_out   = 8'h00;
    byte_first = 1'b0;
    byte_last  = 1'b0;
    unique case (state_q)
      StSof: begin
        byte_out   = SOF_BYTE;
        byte_first = 1'b1;
      end
      StLen:    byte_out = len_byte;
      StDataHi: byte_out = rd_word[15:8];
      StDataLo: byte_out = rd_word[7:0];
      StCsum: begin
        byte_out  = csum_q ^ len_byte;
        byte_last = 1'b1;
      end
      default: byte_out = 8'h00;
    endcase
  end

  assign word_ready = (state_q == StCollect);
  assign byte_valid = (state_q != StCollect);
  assign pkt_sent   = pkt_sent_q;

endmodule
